// File: rtl/control_fsm_pkg.sv
// control_fsm_pkg -- shared encodings for the CPU control FSM.
//
// Holds the state encodings (5 bits), the opcode/op values decoded at DEC,
// the nsel / vsel / mem_cmd encodings seen by the datapath and memory, and the
// packed control word that the FSM drives out of each state.
//
// Configuration: S_HALT exists only when CTRL_HALT_EN is defined.

package control_fsm_pkg;

    // State encodings
    localparam logic [4:0] S_RST  = 5'd0;
    localparam logic [4:0] S_IF1  = 5'd1;
    localparam logic [4:0] S_IF2  = 5'd2;
    localparam logic [4:0] S_UPC  = 5'd3;
    localparam logic [4:0] S_DEC  = 5'd4;
    localparam logic [4:0] S_WIMM = 5'd5;
    localparam logic [4:0] S_GETA = 5'd6;
    localparam logic [4:0] S_GETB = 5'd7;
    localparam logic [4:0] S_EXE  = 5'd8;   // ALU operation into C
    localparam logic [4:0] S_EXM  = 5'd9;   // MOV reg: 0 + B into C
    localparam logic [4:0] S_CMP  = 5'd10;  // ALU CMP: status only
    localparam logic [4:0] S_WREG = 5'd11;
    localparam logic [4:0] S_ADR  = 5'd12;
    localparam logic [4:0] S_LADR = 5'd13;
    localparam logic [4:0] S_RDM  = 5'd14;
    localparam logic [4:0] S_WMEM = 5'd15;
    localparam logic [4:0] S_GETD = 5'd16;
    localparam logic [4:0] S_PASS = 5'd17;
    localparam logic [4:0] S_STM  = 5'd18;
`ifdef CTRL_HALT_EN
    localparam logic [4:0] S_HALT = 5'd19;
`endif

    // Opcodes and ALU op values
    localparam logic [2:0] OPC_MOV  = 3'b110;
    localparam logic [2:0] OPC_ALU  = 3'b101;
    localparam logic [2:0] OPC_LDR  = 3'b011;
    localparam logic [2:0] OPC_STR  = 3'b100;
    localparam logic [2:0] OPC_HALT = 3'b111;
    localparam logic [1:0] OP_MOVIMM = 2'b10;
    localparam logic [1:0] OP_MOVREG = 2'b00;
    localparam logic [1:0] OP_CMP    = 2'b01;
    localparam logic [1:0] OP_MEM    = 2'b00;

    // Register select to the instruction decoder
    localparam logic [1:0] NSEL_RN = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RM = 2'b10;

    // Writeback mux select
    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_IMM   = 2'b01;
    localparam logic [1:0] VSEL_MDATA = 2'b10;

    // Memory command
    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef struct packed {
        logic [1:0] nsel;
        logic [1:0] vsel;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic       write;
        logic       load_ir;
        logic       load_pc;
        logic       reset_pc;
        logic       addr_sel;
        logic       load_addr;
        logic [1:0] mem_cmd;
        logic       w;
    } ctrl_t;

    // Control word with every enable off and the selects at their idle values.
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c         = '0;
        c.nsel    = NSEL_RN;
        c.vsel    = VSEL_C;
        c.mem_cmd = MEM_NONE;
        return c;
    endfunction

endpackage

// File: rtl/control_fsm.sv
// control_fsm -- Moore control FSM for the multicycle CPU.
//
// Fetches an instruction (IF1, IF2, UPC), decodes it (DEC) and sequences its
// execution through the datapath, one instruction per pass, no pipelining.
// Outputs depend only on the current state.
//
// Ports:
//   clk                         rising-edge clock
//   reset                       synchronous, active-high; next state RST
//   opcode[2:0], op[1:0]        from the instruction decoder
//   nsel[1:0]                   register select back to the decoder
//   vsel[1:0]                   writeback mux select
//   loada/loadb/loadc/loads     datapath register enables
//   asel, bsel                  A-operand zero / B-operand sximm5 select
//   write                       register-file write enable
//   load_ir, load_pc, reset_pc  IR / PC control
//   addr_sel, load_addr         memory address source / data address enable
//   mem_cmd[1:0]                memory command
//   w                           high in RST (and HALT)
//
// Configuration: define CTRL_HALT_EN to add the HALT instruction (opcode 111);
// otherwise opcode 111 executes as a NOP.

module control_fsm
    import control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    output logic [1:0] nsel,
    output logic [1:0] vsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic       reset_pc,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       w
);

    logic [4:0] state_q, state_d;
    ctrl_t      ctrl;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // Later shared states (GETA, GETB, LADR) branch on opcode/op again; the IR
    // is held for the whole instruction so the decoder outputs stay stable.
    always_comb begin
        state_d = S_RST;
        case (state_q)
            S_RST:  state_d = S_IF1;
            S_IF1:  state_d = S_IF2;
            S_IF2:  state_d = S_UPC;
            S_UPC:  state_d = S_DEC;
            S_DEC: begin
                state_d = S_IF1;  // undefined encodings fall through as a NOP
                if (opcode == OPC_MOV && op == OP_MOVIMM) begin
                    state_d = S_WIMM;
                end else if (opcode == OPC_MOV && op == OP_MOVREG) begin
                    state_d = S_GETB;
                end else if (opcode == OPC_ALU) begin
                    state_d = S_GETA;
                end else if ((opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM) begin
                    state_d = S_GETA;
`ifdef CTRL_HALT_EN
                end else if (opcode == OPC_HALT) begin
                    state_d = S_HALT;
`endif
                end
            end
            S_WIMM: state_d = S_IF1;
            S_GETA: state_d = (opcode == OPC_ALU) ? S_GETB : S_ADR;
            S_GETB: begin
                if (opcode == OPC_MOV) begin
                    state_d = S_EXM;
                end else if (op == OP_CMP) begin
                    state_d = S_CMP;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE:  state_d = S_WREG;
            S_EXM:  state_d = S_WREG;
            S_CMP:  state_d = S_IF1;
            S_WREG: state_d = S_IF1;
            S_ADR:  state_d = S_LADR;
            S_LADR: state_d = (opcode == OPC_LDR) ? S_RDM : S_GETD;
            S_RDM:  state_d = S_WMEM;
            S_WMEM: state_d = S_IF1;
            S_GETD: state_d = S_PASS;
            S_PASS: state_d = S_STM;
            S_STM:  state_d = S_IF1;
`ifdef CTRL_HALT_EN
            S_HALT: state_d = S_HALT;
`endif
            default: state_d = S_RST;  // illegal encoding recovers through RST
        endcase
    end

    always_comb begin
        ctrl = ctrl_idle();
        case (state_q)
            S_RST: begin
                ctrl.reset_pc = 1'b1;
                ctrl.load_pc  = 1'b1;
                ctrl.w        = 1'b1;
            end
            S_IF1: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_cmd  = MEM_READ;
            end
            S_IF2: begin
                ctrl.addr_sel = 1'b1;
                ctrl.mem_cmd  = MEM_READ;
                ctrl.load_ir  = 1'b1;
            end
            S_UPC:  ctrl.load_pc = 1'b1;
            S_WIMM: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.vsel  = VSEL_IMM;
                ctrl.write = 1'b1;
            end
            S_GETA: begin
                ctrl.nsel  = NSEL_RN;
                ctrl.loada = 1'b1;
            end
            S_GETB: begin
                ctrl.nsel  = NSEL_RM;
                ctrl.loadb = 1'b1;
            end
            S_EXE:  ctrl.loadc = 1'b1;
            S_EXM, S_PASS: begin
                ctrl.asel  = 1'b1;
                ctrl.loadc = 1'b1;
            end
            S_CMP:  ctrl.loads = 1'b1;
            S_WREG: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.write = 1'b1;
            end
            S_ADR: begin
                ctrl.bsel  = 1'b1;
                ctrl.loadc = 1'b1;
            end
            S_LADR: ctrl.load_addr = 1'b1;
            S_RDM:  ctrl.mem_cmd = MEM_READ;
            S_WMEM: begin
                ctrl.nsel    = NSEL_RD;
                ctrl.vsel    = VSEL_MDATA;
                ctrl.write   = 1'b1;
                ctrl.mem_cmd = MEM_READ;
            end
            S_GETD: begin
                ctrl.nsel  = NSEL_RD;
                ctrl.loadb = 1'b1;
            end
            S_STM:  ctrl.mem_cmd = MEM_WRITE;
`ifdef CTRL_HALT_EN
            S_HALT: ctrl.w = 1'b1;
`endif
            default: ;  // DEC and illegal encodings: everything idle
        endcase
    end

    assign nsel      = ctrl.nsel;
    assign vsel      = ctrl.vsel;
    assign loada     = ctrl.loada;
    assign loadb     = ctrl.loadb;
    assign loadc     = ctrl.loadc;
    assign loads     = ctrl.loads;
    assign asel      = ctrl.asel;
    assign bsel      = ctrl.bsel;
    assign write     = ctrl.write;
    assign load_ir   = ctrl.load_ir;
    assign load_pc   = ctrl.load_pc;
    assign reset_pc  = ctrl.reset_pc;
    assign addr_sel  = ctrl.addr_sel;
    assign load_addr = ctrl.load_addr;
    assign mem_cmd   = ctrl.mem_cmd;
    assign w         = ctrl.w;

endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm -- scoreboard bench for control_fsm.
//
// For every cycle the driver pushes the control word the specification
// requires for the state the FSM should be in; a negedge monitor pops it and
// compares it against the full output vector. Works with or without
// CTRL_HALT_EN.

module tb_control_fsm;
    import control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] opcode;
    logic [1:0] op;
    logic [1:0] nsel, vsel, mem_cmd;
    logic       loada, loadb, loadc, loads, asel, bsel, write;
    logic       load_ir, load_pc, reset_pc, addr_sel, load_addr, w;

    always #5 clk = ~clk;

    control_fsm dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .op        (op),
        .nsel      (nsel),
        .vsel      (vsel),
        .loada     (loada),
        .loadb     (loadb),
        .loadc     (loadc),
        .loads     (loads),
        .asel      (asel),
        .bsel      (bsel),
        .write     (write),
        .load_ir   (load_ir),
        .load_pc   (load_pc),
        .reset_pc  (reset_pc),
        .addr_sel  (addr_sel),
        .load_addr (load_addr),
        .mem_cmd   (mem_cmd),
        .w         (w)
    );

    logic [18:0] obs_word;
    assign obs_word = {nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write,
                       load_ir, load_pc, reset_pc, addr_sel, load_addr, mem_cmd, w};

    // Bench-side state names
    localparam int T_RST  = 0;
    localparam int T_IF1  = 1;
    localparam int T_IF2  = 2;
    localparam int T_UPC  = 3;
    localparam int T_DEC  = 4;
    localparam int T_WIMM = 5;
    localparam int T_GETA = 6;
    localparam int T_GETB = 7;
    localparam int T_EXE  = 8;
    localparam int T_EXEM = 9;
    localparam int T_CMPX = 10;
    localparam int T_WREG = 11;
    localparam int T_ADR  = 12;
    localparam int T_LADR = 13;
    localparam int T_RDM  = 14;
    localparam int T_WMEM = 15;
    localparam int T_GETD = 16;
    localparam int T_PASS = 17;
    localparam int T_STM  = 18;
    localparam int T_HALT = 19;

    typedef struct {
        string       tag;
        logic [18:0] word;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;
    string cur_instr = "";

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    function automatic string st_name(input int t);
        case (t)
            T_RST:  return "RST";
            T_IF1:  return "IF1";
            T_IF2:  return "IF2";
            T_UPC:  return "UPC";
            T_DEC:  return "DEC";
            T_WIMM: return "WIMM";
            T_GETA: return "GETA";
            T_GETB: return "GETB";
            T_EXE:  return "EXE";
            T_EXEM: return "EXE_MOV";
            T_CMPX: return "EXE_CMP";
            T_WREG: return "WREG";
            T_ADR:  return "ADR";
            T_LADR: return "LADR";
            T_RDM:  return "RDM";
            T_WMEM: return "WMEM";
            T_GETD: return "GETD";
            T_PASS: return "PASS";
            T_STM:  return "STM";
            default: return "HALT";
        endcase
    endfunction

    // Required control word for each state, straight from the behaviour list.
    function automatic logic [18:0] exp_word(input int t);
        logic [1:0] ns, vs, mc;
        logic la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, ads, lad, wv;
        ns = NSEL_RN; vs = VSEL_C; mc = MEM_NONE;
        {la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, ads, lad, wv} = '0;
        case (t)
            T_RST:  begin rpc = 1; lpc = 1; wv = 1; end
            T_IF1:  begin ads = 1; mc = MEM_READ; end
            T_IF2:  begin ads = 1; mc = MEM_READ; lir = 1; end
            T_UPC:  lpc = 1;
            T_WIMM: begin vs = VSEL_IMM; wr = 1; end
            T_GETA: la = 1;
            T_GETB: begin ns = NSEL_RM; lb = 1; end
            T_EXE:  lc = 1;
            T_EXEM: begin as = 1; lc = 1; end
            T_CMPX: ls = 1;
            T_WREG: begin ns = NSEL_RD; wr = 1; end
            T_ADR:  begin bs = 1; lc = 1; end
            T_LADR: lad = 1;
            T_RDM:  mc = MEM_READ;
            T_WMEM: begin ns = NSEL_RD; vs = VSEL_MDATA; wr = 1; mc = MEM_READ; end
            T_GETD: begin ns = NSEL_RD; lb = 1; end
            T_PASS: begin as = 1; lc = 1; end
            T_STM:  mc = MEM_WRITE;
            T_HALT: wv = 1;
            default: ;
        endcase
        return {ns, vs, la, lb, lc, ls, as, bs, wr, lir, lpc, rpc, ads, lad, mc, wv};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, {13'd0, obs_word}, {13'd0, e.word});
        end
    end

    task automatic expect_state(input int t);
        exp_t e;
        e.tag  = {cur_instr, ".", st_name(t)};
        e.word = exp_word(t);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int t);
        expect_state(t);
        tick();
    endtask

    // Entered just after the edge that puts the FSM in IF1; leaves it in IF1.
    task automatic run_instr(input string name, input logic [2:0] opc, input logic [1:0] o);
        cur_instr = name;
        opcode    = opc;
        op        = o;
        step(T_IF1); step(T_IF2); step(T_UPC); step(T_DEC);
        if (opc == 3'b110 && o == 2'b10) begin
            step(T_WIMM);
        end else if (opc == 3'b110 && o == 2'b00) begin
            step(T_GETB); step(T_EXEM); step(T_WREG);
        end else if (opc == 3'b101 && o == 2'b01) begin
            step(T_GETA); step(T_GETB); step(T_CMPX);
        end else if (opc == 3'b101) begin
            step(T_GETA); step(T_GETB); step(T_EXE); step(T_WREG);
        end else if (opc == 3'b011 && o == 2'b00) begin
            step(T_GETA); step(T_ADR); step(T_LADR); step(T_RDM); step(T_WMEM);
        end else if (opc == 3'b100 && o == 2'b00) begin
            step(T_GETA); step(T_ADR); step(T_LADR); step(T_GETD); step(T_PASS); step(T_STM);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        opcode = 3'b000;
        op     = 2'b00;

        // Reset held for two edges, then released.
        cur_instr = "RESET";
        tick();
        step(T_RST);
        reset = 1'b0;
        step(T_RST);

        run_instr("NOP000", 3'b000, 2'b00);
        run_instr("MOVIMM", 3'b110, 2'b10);
        run_instr("MOVREG", 3'b110, 2'b00);
        run_instr("ADD",    3'b101, 2'b00);
        run_instr("CMP",    3'b101, 2'b01);
        run_instr("AND",    3'b101, 2'b10);
        run_instr("LDR",    3'b011, 2'b00);
        run_instr("STR",    3'b100, 2'b00);
        run_instr("MOV01",  3'b110, 2'b01);
        run_instr("STR11",  3'b100, 2'b11);

        // Reset arriving while an LDR sits in RDM: no writeback afterwards.
        cur_instr = "LDRRST";
        opcode    = 3'b011;
        op        = 2'b00;
        step(T_IF1); step(T_IF2); step(T_UPC); step(T_DEC);
        step(T_GETA); step(T_ADR); step(T_LADR);
        expect_state(T_RDM);
        reset = 1'b1;
        tick();
        expect_state(T_RST);
        reset = 1'b0;
        tick();

`ifdef CTRL_HALT_EN
        cur_instr = "HALT";
        opcode    = 3'b111;
        op        = 2'b00;
        step(T_IF1); step(T_IF2); step(T_UPC); step(T_DEC);
        repeat (20) step(T_HALT);
        expect_state(T_HALT);
        reset = 1'b1;
        tick();
        expect_state(T_RST);
        reset = 1'b0;
        tick();
`else
        run_instr("OP111", 3'b111, 2'b00);
`endif

        run_instr("ADD2", 3'b101, 2'b11);

        @(negedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
